// File: rtl/mlaccel_pkg.sv
// Shared definitions for the ML accelerator QPI control slice.
// Holds the command byte codes, the status-byte bit positions, and the FSM
// state types used by the command decoder and the copy engine.
package mlaccel_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_NOP    = 8'h20;  // no args; clears err on its stop
    localparam logic [7:0] CMD_WRBUF  = 8'h21;  // stream bytes into the staging buffer
    localparam logic [7:0] CMD_COPY   = 8'h23;  // addr lo, addr hi, len -> copy to memory
    localparam logic [7:0] CMD_LAUNCH = 8'h25;  // pc lo, pc hi -> start the core

    // Status byte layout: {err, 5'b0, core_busy, copy_busy}
    localparam int unsigned STATUS_ERR_BIT  = 7;
    localparam int unsigned STATUS_CORE_BIT = 1;
    localparam int unsigned STATUS_COPY_BIT = 0;

    typedef enum logic [1:0] {
        S_CMD,
        S_WRBUF,
        S_ARGS,
        S_IGNORE
    } cmd_state_e;

    typedef enum logic [1:0] {
        C_IDLE,
        C_RD,
        C_WR
    } copy_state_e;

    function automatic logic [7:0] make_status(logic err, logic core_busy, logic copy_busy);
        logic [7:0] s;
        s                  = '0;
        s[STATUS_ERR_BIT]  = err;
        s[STATUS_CORE_BIT] = core_busy;
        s[STATUS_COPY_BIT] = copy_busy;
        return s;
    endfunction

endpackage

// File: rtl/mlaccel_ctrl_if.sv
// Staging-buffer and main-memory bus bundle for mlaccel_ctrl.
//   buf_we/buf_waddr/buf_wdata : byte writes into the staging buffer
//   buf_raddr/buf_rdata        : word reads, data valid one cycle after address
//   mem_wen/mem_addr/mem_wdata : main-memory word write (addr in halfwords)
//   mem_ready                  : memory accepts the write in the cycle it is high
// master = controller side, slave = buffer/memory side.
interface mlaccel_ctrl_if #(
    parameter int unsigned BUF_WORDS = 256
) ();
    localparam int unsigned RAW = $clog2(BUF_WORDS);
    localparam int unsigned WAW = $clog2(BUF_WORDS * 4);

    logic           buf_we;
    logic [WAW-1:0] buf_waddr;
    logic [7:0]     buf_wdata;
    logic [RAW-1:0] buf_raddr;
    logic [31:0]    buf_rdata;
    logic           mem_wen;
    logic [15:0]    mem_addr;
    logic [31:0]    mem_wdata;
    logic           mem_ready;

    modport master (
        output buf_we, buf_waddr, buf_wdata, buf_raddr, mem_wen, mem_addr, mem_wdata,
        input  buf_rdata, mem_ready
    );

    modport slave (
        input  buf_we, buf_waddr, buf_wdata, buf_raddr, mem_wen, mem_addr, mem_wdata,
        output buf_rdata, mem_ready
    );

endinterface

// File: rtl/mlaccel_copy.sv
// Copy engine: moves len words from the staging buffer (starting at word 0)
// into main memory at addr, addr+2, ... (halfword units, wrapping at 2^16).
// Ports:
//   clock, resetn        : clock, async active-low reset (aborts any copy)
//   start, addr, len     : one-cycle request; len=0 is ignored
//   busy                 : high while a copy is in progress
//   buf_raddr, buf_rdata : staging-buffer word read, 1-cycle latency
//   mem_wen, mem_addr, mem_wdata, mem_ready : memory write handshake
module mlaccel_copy
    import mlaccel_pkg::*;
#(
    parameter int unsigned BUF_WORDS = 256,
    localparam int unsigned RAW = $clog2(BUF_WORDS)
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start,
    input  logic [15:0]    addr,
    input  logic [7:0]     len,
    output logic           busy,
    output logic [RAW-1:0] buf_raddr,
    input  logic [31:0]    buf_rdata,
    output logic           mem_wen,
    output logic [15:0]    mem_addr,
    output logic [31:0]    mem_wdata,
    input  logic           mem_ready
);

    copy_state_e    state_q, state_d;
    logic [RAW-1:0] raddr_q, raddr_d;
    logic [15:0]    addr_q, addr_d;
    logic [7:0]     remain_q, remain_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           held_q, held_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= C_IDLE;
            raddr_q  <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            wdata_q  <= '0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            wdata_q  <= wdata_d;
            held_q   <= held_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        wdata_d  = wdata_q;
        held_d   = held_q;
        case (state_q)
            C_IDLE: begin
                if (start && (len != 8'd0)) begin
                    addr_d   = addr;
                    remain_d = len;
                    raddr_d  = '0;
                    state_d  = C_RD;
                end
            end
            C_RD: begin
                held_d  = 1'b0;
                state_d = C_WR;
            end
            C_WR: begin
                // Buffer data is only guaranteed in the first C_WR cycle; latch it
                // so the write data stays put however long mem_ready takes.
                if (!held_q) begin
                    wdata_d = buf_rdata;
                    held_d  = 1'b1;
                end
                if (mem_ready) begin
                    held_d   = 1'b0;
                    addr_d   = addr_q + 16'd2;
                    raddr_d  = raddr_q + 1'b1;
                    remain_d = remain_q - 8'd1;
                    state_d  = (remain_q == 8'd1) ? C_IDLE : C_RD;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    assign busy      = (state_q != C_IDLE);
    assign buf_raddr = raddr_q;
    assign mem_wen   = (state_q == C_WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = (state_q == C_WR) ? (held_q ? wdata_q : buf_rdata) : 32'd0;

endmodule

// File: rtl/mlaccel_ctrl.sv
// QPI command decoder for the ML accelerator. Parses one host transaction per
// chip-select (first byte = command), streams buffer writes, launches the copy
// engine and the compute core, and reports a status byte.
// Ports:
//   clock, resetn              : clock, async active-low reset
//   in_valid, in_data, in_stop : received byte stream; in_stop ends a transaction
//   status                     : {err, 5'b0, core_busy, copy_busy}
//   core_start, core_pc        : one-cycle launch pulse and entry point
//   core_busy                  : core is running
//   bus                        : staging-buffer and memory bus (master side)
module mlaccel_ctrl
    import mlaccel_pkg::*;
#(
    parameter int unsigned BUF_WORDS = 256
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_stop,
    output logic [7:0]   status,
    output logic         core_start,
    output logic [15:0]  core_pc,
    input  logic         core_busy,
    mlaccel_ctrl_if.master bus
);

    localparam int unsigned RAW = $clog2(BUF_WORDS);
    localparam int unsigned WAW = $clog2(BUF_WORDS * 4);

    cmd_state_e     state_q, state_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [1:0]     arg_cnt_q, arg_cnt_d;
    logic [7:0]     arg0_q, arg0_d;
    logic [7:0]     arg1_q, arg1_d;
    logic [WAW-1:0] wptr_q, wptr_d;
    logic           err_q, err_d;
    logic           buf_we_q, buf_we_d;
    logic [WAW-1:0] buf_waddr_q, buf_waddr_d;
    logic [7:0]     buf_wdata_q, buf_wdata_d;
    logic           core_start_q, core_start_d;
    logic [15:0]    core_pc_q, core_pc_d;
    logic           copy_start_q, copy_start_d;
    logic [15:0]    copy_addr_q, copy_addr_d;
    logic [7:0]     copy_len_q, copy_len_d;

    logic           engine_busy;
    logic           copy_busy;
    logic [RAW-1:0] copy_raddr;
    logic           copy_wen;
    logic [15:0]    copy_maddr;
    logic [31:0]    copy_wdata;

    // A request registered but not yet seen by the engine already counts as busy.
    assign copy_busy = engine_busy | copy_start_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_CMD;
            cmd_q        <= '0;
            arg_cnt_q    <= '0;
            arg0_q       <= '0;
            arg1_q       <= '0;
            wptr_q       <= '0;
            err_q        <= 1'b0;
            buf_we_q     <= 1'b0;
            buf_waddr_q  <= '0;
            buf_wdata_q  <= '0;
            core_start_q <= 1'b0;
            core_pc_q    <= '0;
            copy_start_q <= 1'b0;
            copy_addr_q  <= '0;
            copy_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            arg_cnt_q    <= arg_cnt_d;
            arg0_q       <= arg0_d;
            arg1_q       <= arg1_d;
            wptr_q       <= wptr_d;
            err_q        <= err_d;
            buf_we_q     <= buf_we_d;
            buf_waddr_q  <= buf_waddr_d;
            buf_wdata_q  <= buf_wdata_d;
            core_start_q <= core_start_d;
            core_pc_q    <= core_pc_d;
            copy_start_q <= copy_start_d;
            copy_addr_q  <= copy_addr_d;
            copy_len_q   <= copy_len_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        arg_cnt_d    = arg_cnt_q;
        arg0_d       = arg0_q;
        arg1_d       = arg1_q;
        wptr_d       = wptr_q;
        err_d        = err_q;
        buf_we_d     = 1'b0;
        buf_waddr_d  = buf_waddr_q;
        buf_wdata_d  = buf_wdata_q;
        core_start_d = 1'b0;
        core_pc_d    = core_pc_q;
        copy_start_d = 1'b0;
        copy_addr_d  = copy_addr_q;
        copy_len_d   = copy_len_q;

        if (in_valid) begin
            case (state_q)
                S_CMD: begin
                    cmd_d     = in_data;
                    arg_cnt_d = 2'd0;
                    case (in_data)
                        CMD_NOP:   state_d = S_IGNORE;
                        CMD_WRBUF: begin
                            state_d = S_WRBUF;
                            wptr_d  = '0;
                        end
                        CMD_COPY, CMD_LAUNCH: state_d = S_ARGS;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_IGNORE;
                        end
                    endcase
                end
                S_WRBUF: begin
                    buf_we_d    = 1'b1;
                    buf_waddr_d = wptr_q;
                    buf_wdata_d = in_data;
                    wptr_d      = wptr_q + 1'b1;  // wraps over the whole buffer
                end
                S_ARGS: begin
                    arg_cnt_d = arg_cnt_q + 2'd1;
                    if (arg_cnt_q == 2'd0) begin
                        arg0_d = in_data;
                    end else if (arg_cnt_q == 2'd1) begin
                        arg1_d = in_data;
                        if (cmd_q == CMD_LAUNCH) begin
                            state_d = S_IGNORE;
                            if (copy_busy || core_busy) begin
                                err_d = 1'b1;
                            end else begin
                                core_start_d = 1'b1;
                                core_pc_d    = {in_data, arg0_q};
                            end
                        end
                    end else begin
                        state_d = S_IGNORE;
                        if (copy_busy) begin
                            err_d = 1'b1;  // overlapping copy request is dropped
                        end else begin
                            copy_start_d = 1'b1;
                            copy_addr_d  = {arg1_q, arg0_q};
                            copy_len_d   = in_data;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Stop is applied after any byte arriving in the same cycle.
        if (in_stop) begin
            if (state_d == S_ARGS) begin
                err_d = 1'b1;
            end else if ((state_d == S_IGNORE) && (cmd_d == CMD_NOP)) begin
                err_d = 1'b0;
            end
            state_d = S_CMD;
        end
    end

    mlaccel_copy #(
        .BUF_WORDS (BUF_WORDS)
    ) u_copy (
        .clock     (clock),
        .resetn    (resetn),
        .start     (copy_start_q),
        .addr      (copy_addr_q),
        .len       (copy_len_q),
        .busy      (engine_busy),
        .buf_raddr (copy_raddr),
        .buf_rdata (bus.buf_rdata),
        .mem_wen   (copy_wen),
        .mem_addr  (copy_maddr),
        .mem_wdata (copy_wdata),
        .mem_ready (bus.mem_ready)
    );

    assign bus.buf_we    = buf_we_q;
    assign bus.buf_waddr = buf_waddr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign bus.buf_raddr = copy_raddr;
    assign bus.mem_wen   = copy_wen;
    assign bus.mem_addr  = copy_maddr;
    assign bus.mem_wdata = copy_wdata;

    assign core_start = core_start_q;
    assign core_pc    = core_pc_q;
    assign status     = make_status(err_q, core_busy, copy_busy);

endmodule

// File: tb/tb_mlaccel_ctrl.sv
// Directed bench for mlaccel_ctrl: a transaction-level model predicts buffer
// writes, memory writes, core launches and the err flag; a compare process
// checks every DUT event against those predictions.
module tb_mlaccel_ctrl;
    import mlaccel_pkg::*;

    localparam int unsigned BUF_WORDS = 256;
    localparam int unsigned NBYTES    = BUF_WORDS * 4;

    logic        clock     = 1'b0;
    logic        resetn    = 1'b0;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_data   = 8'h00;
    logic        in_stop   = 1'b0;
    logic        core_busy = 1'b0;
    logic [7:0]  status;
    logic        core_start;
    logic [15:0] core_pc;

    mlaccel_ctrl_if #(.BUF_WORDS(BUF_WORDS)) bus ();

    mlaccel_ctrl #(.BUF_WORDS(BUF_WORDS)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_stop    (in_stop),
        .status     (status),
        .core_start (core_start),
        .core_pc    (core_pc),
        .core_busy  (core_busy),
        .bus        (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_buf[$];
    wr_t         exp_mem[$];
    wr_t         obs_buf[$];
    wr_t         obs_mem[$];
    logic [15:0] exp_pc[$];
    logic [31:0] shadow[BUF_WORDS];
    logic [31:0] ram[BUF_WORDS];
    logic        m_err;
    int          n_starts = 0;
    logic [15:0] last_pc  = 16'h0;
    int          ready_delay = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Staging buffer: byte writes, little-endian lanes, 1-cycle word read.
    always @(posedge clock) begin
        if (bus.buf_we) ram[bus.buf_waddr[9:2]][8*bus.buf_waddr[1:0] +: 8] <= bus.buf_wdata;
        bus.buf_rdata <= ram[bus.buf_raddr];
    end

    // Memory: accept after ready_delay extra cycles of mem_wen.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!resetn || !bus.mem_wen) begin
                bus.mem_ready = 1'b0;
                wcnt = 0;
            end else if (!bus.mem_ready) begin
                if (wcnt >= ready_delay) bus.mem_ready = 1'b1;
                else wcnt++;
            end
        end
    end

    // Transaction-level model: effects of one complete host transaction.
    task automatic model_txn(input logic [7:0] b[$]);
        int n;
        n = b.size();
        if (n == 0) return;
        case (b[0])
            CMD_NOP: m_err = 1'b0;
            CMD_WRBUF: begin
                for (int k = 1; k < n; k++) begin
                    int a;
                    a = (k - 1) % NBYTES;
                    exp_buf.push_back('{a: 16'(a), d: 32'(b[k])});
                    shadow[a / 4][8 * (a % 4) +: 8] = b[k];
                end
            end
            CMD_COPY: begin
                if (n < 4 || exp_mem.size() != 0) begin
                    m_err = 1'b1;
                end else begin
                    for (int i = 0; i < int'(b[3]); i++)
                        exp_mem.push_back('{a: 16'({b[2], b[1]} + 16'(2 * i)),
                                            d: shadow[i % BUF_WORDS]});
                end
            end
            CMD_LAUNCH: begin
                if (n < 3 || exp_mem.size() != 0 || core_busy) m_err = 1'b1;
                else exp_pc.push_back({b[2], b[1]});
            end
            default: m_err = 1'b1;
        endcase
    endtask

    task automatic send(input logic [7:0] b[$], input bit stop_same);
        model_txn(b);
        for (int i = 0; i < b.size(); i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = b[i];
            in_stop  = stop_same && (i == b.size() - 1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_stop  = 1'b0;
        if (!stop_same) begin
            in_stop = 1'b1;
            @(negedge clock);
            in_stop = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((status[0] !== 1'b0 || exp_mem.size() != 0) && t < 500) begin
            @(negedge clock);
            t++;
        end
        chk({name, "_timeout"}, 32'(t < 500), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_status(input string name);
        chk(name, status, {m_err, 5'b0, core_busy, 1'b0});
    endtask

    // Compare process: every DUT event against the model.
    initial begin
        logic        prev_wen, prev_rdy;
        logic [15:0] prev_a;
        logic [31:0] prev_d;
        wr_t         e;
        prev_wen = 1'b0;
        prev_rdy = 1'b0;
        prev_a   = '0;
        prev_d   = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                chk("reset_quiet", {29'd0, bus.buf_we, bus.mem_wen, core_start}, 32'd0);
                prev_wen = 1'b0;
            end else begin
                if (bus.buf_we) begin
                    obs_buf.push_back('{a: 16'(bus.buf_waddr), d: 32'(bus.buf_wdata)});
                    if (exp_buf.size() == 0) begin
                        chk("buf_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_buf.pop_front();
                        chk("buf_waddr", 32'(bus.buf_waddr), 32'(e.a));
                        chk("buf_wdata", 32'(bus.buf_wdata), e.d);
                    end
                end
                if (bus.mem_wen) begin
                    if (prev_wen && !prev_rdy) begin
                        chk("mem_addr_hold", 32'(bus.mem_addr), 32'(prev_a));
                        chk("mem_wdata_hold", bus.mem_wdata, prev_d);
                    end
                    if (bus.mem_ready) begin
                        obs_mem.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
                        if (exp_mem.size() == 0) begin
                            chk("mem_unexpected", 32'd1, 32'd0);
                        end else begin
                            e = exp_mem.pop_front();
                            chk("mem_addr", 32'(bus.mem_addr), 32'(e.a));
                            chk("mem_wdata", bus.mem_wdata, e.d);
                        end
                    end
                end
                prev_wen = bus.mem_wen;
                prev_rdy = bus.mem_ready;
                prev_a   = bus.mem_addr;
                prev_d   = bus.mem_wdata;
                if (core_start) begin
                    n_starts++;
                    last_pc = core_pc;
                    if (exp_pc.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
                    else chk("core_pc", 32'(core_pc), 32'(exp_pc.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] tx[$];
        int t, n_before;
        m_err = 1'b0;
        for (int i = 0; i < int'(BUF_WORDS); i++) shadow[i] = 32'h0;

        repeat (3) @(negedge clock);
        chk("rst_status", 32'(status), 32'h00);
        chk("rst_core_pc", 32'(core_pc), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_buf_raddr", 32'(bus.buf_raddr), 32'h0);
        resetn = 1'b1;
        @(negedge clock);

        // Buffer write: bytes land at 0..7
        tx = '{8'h21, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send(tx, 1'b0);
        repeat (2) @(negedge clock);
        chk("wrbuf_count", obs_buf.size(), 8);
        chk("wrbuf0_addr", 32'(obs_buf[0].a), 32'd0);
        chk("wrbuf0_data", obs_buf[0].d, 32'h11);
        chk("wrbuf3_addr", 32'(obs_buf[3].a), 32'd3);
        chk("wrbuf3_data", obs_buf[3].d, 32'h44);
        chk_status("wrbuf_status");

        // Copy 2 words to 0x1000 with slow memory
        ready_delay = 3;
        tx = '{8'h23, 8'h00, 8'h10, 8'h02};
        send(tx, 1'b0);
        repeat (3) @(negedge clock);
        chk("copy1_busy_status", 32'(status), 32'h01);
        wait_idle("copy1");
        chk("copy1_status", 32'(status), 32'h00);
        chk("copy1_n", obs_mem.size(), 2);
        chk("copy1_a0", 32'(obs_mem[0].a), 32'h1000);
        chk("copy1_d0", obs_mem[0].d, 32'h44332211);
        chk("copy1_a1", 32'(obs_mem[1].a), 32'h1002);
        chk("copy1_d1", obs_mem[1].d, 32'h88776655);

        // Launch with idle core, then with busy core
        ready_delay = 0;
        tx = '{8'h25, 8'h00, 8'h00};
        send(tx, 1'b0);
        repeat (2) @(negedge clock);
        chk("launch_count", n_starts, 1);
        chk("launch_pc", 32'(last_pc), 32'h0000);
        chk("launch_status", 32'(status), 32'h00);
        core_busy = 1'b1;
        tx = '{8'h25, 8'h34, 8'h12};
        send(tx, 1'b0);
        repeat (2) @(negedge clock);
        chk("launch_busy_status", 32'(status), 32'h82);
        chk("launch_busy_count", n_starts, 1);
        core_busy = 1'b0;
        @(negedge clock);
        chk("launch_busy_status2", 32'(status), 32'h80);

        // 0x20 with ignored bytes clears err
        tx = '{8'h20, 8'hAA, 8'h23};
        send(tx, 1'b0);
        chk("nop_clear", 32'(status), 32'h00);

        // Truncated copy
        tx = '{8'h23, 8'h00, 8'h10};
        send(tx, 1'b0);
        repeat (2) @(negedge clock);
        chk("short_status", 32'(status), 32'h80);
        chk("short_no_copy", obs_mem.size(), 2);
        tx = '{8'h20};
        send(tx, 1'b0);
        chk("short_clear", 32'(status), 32'h00);

        // Address wrap at 0xFFFE
        tx = '{8'h23, 8'hFE, 8'hFF, 8'h02};
        send(tx, 1'b0);
        wait_idle("wrap_addr");
        chk("wrap_a0", 32'(obs_mem[2].a), 32'hFFFE);
        chk("wrap_a1", 32'(obs_mem[3].a), 32'h0000);
        chk("wrap_d1", obs_mem[3].d, 32'h88776655);
        chk_status("wrap_status");

        // Unknown command, then 0x20 whose stop shares its cycle
        tx = '{8'h55, 8'h21};
        send(tx, 1'b0);
        chk("unknown_status", 32'(status), 32'h80);
        tx = '{8'h20};
        send(tx, 1'b1);
        chk("same_cycle_clear", 32'(status), 32'h00);

        // Launch whose last arg coincides with stop
        tx = '{8'h25, 8'h00, 8'h56};
        send(tx, 1'b1);
        repeat (2) @(negedge clock);
        chk("same_cycle_launch", n_starts, 2);
        chk("same_cycle_pc", 32'(last_pc), 32'h5600);
        chk_status("same_cycle_status");

        // Copy requested while another copy runs
        ready_delay = 10;
        tx = '{8'h23, 8'h00, 8'h20, 8'h02};
        send(tx, 1'b0);
        tx = '{8'h23, 8'h00, 8'h30, 8'h01};
        send(tx, 1'b0);
        wait_idle("overlap");
        chk("overlap_status", 32'(status), 32'h80);
        chk("overlap_n", obs_mem.size(), 6);
        chk("overlap_last_a", 32'(obs_mem[5].a), 32'h2002);
        tx = '{8'h20};
        send(tx, 1'b0);

        // len = 0 is a no-op
        tx = '{8'h23, 8'h00, 8'h50, 8'h00};
        send(tx, 1'b0);
        wait_idle("len0");
        chk("len0_n", obs_mem.size(), 6);
        chk("len0_status", 32'(status), 32'h00);

        // Buffer write address wraps
        tx.delete();
        tx.push_back(8'h21);
        for (int k = 0; k < int'(NBYTES) + 2; k++) tx.push_back(8'(k) ^ 8'h5A);
        send(tx, 1'b0);
        repeat (2) @(negedge clock);
        chk("bufwrap_count", obs_buf.size(), 8 + NBYTES + 2);
        chk("bufwrap_last_addr", 32'(obs_buf[$].a), 32'd1);
        chk("bufwrap_last_data", obs_buf[$].d, 32'h5B);

        // Reset while waiting for mem_ready
        ready_delay = 20;
        tx = '{8'h23, 8'h00, 8'h40, 8'h03};
        send(tx, 1'b0);
        t = 0;
        while (bus.mem_wen !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("rst_reach_wr", 32'(bus.mem_wen), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst_abort_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_abort_status", 32'(status), 32'h00);
        exp_mem.delete();
        m_err = 1'b0;
        n_before = obs_mem.size();
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (40) @(negedge clock);
        chk("rst_no_writes", obs_mem.size(), n_before);
        chk("rst_after_status", 32'(status), 32'h00);

        chk("buf_drained", exp_buf.size(), 0);
        chk("pc_drained", exp_pc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
